// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
// Segment patterns are gfedcba, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam int unsigned DEFAULT_REFRESH_DIV = 1024;
    localparam int unsigned PRESC_W_DEFAULT     = $clog2(DEFAULT_REFRESH_DIV);

    typedef enum logic {
        CONV_IDLE,
        CONV_SHIFT
    } conv_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Counter width for a modulus of n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value-load handshake between the game FSM and the display driver.
interface seg7_scan_driver_if #(
    parameter int unsigned VALUE_WIDTH = 7
);
    logic [VALUE_WIDTH-1:0] value;
    logic                   load;
    logic                   busy;

    modport master (output value, output load, input busy);
    modport slave  (input value, input load, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle.
// done and bcd are combinational so the consumer can latch on the final shift edge.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 7,
    parameter int unsigned NUM_DIGITS  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [VALUE_WIDTH-1:0]  value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int unsigned CNT_W = cnt_width(VALUE_WIDTH + 1);

    conv_state_t state, state_next;
    logic [VALUE_WIDTH-1:0]  shreg;
    logic [4*NUM_DIGITS-1:0] acc;
    logic [4*NUM_DIGITS-1:0] adj;
    logic [4*NUM_DIGITS-1:0] shifted;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              nib;

    always_comb begin
        adj = '0;
        nib = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            nib = acc[4*i +: 4];
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    assign shifted = {adj[4*NUM_DIGITS-2:0], shreg[VALUE_WIDTH-1]};
    assign bcd     = shifted;
    assign busy    = (state == CONV_SHIFT);

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            CONV_IDLE: if (start) state_next = CONV_SHIFT;
            CONV_SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    done       = 1'b1;
                    state_next = CONV_IDLE;
                end
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CONV_IDLE;
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CONV_IDLE && start) begin
                shreg <= value;
                acc   <= '0;
                cnt   <= CNT_W'(VALUE_WIDTH);
            end else if (state == CONV_SHIFT) begin
                shreg <= shreg << 1;
                acc   <= shifted;
                cnt   <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS 7-segment driver: BCD conversion, scan with guard gap,
// leading-zero blanking, overflow dashes and selectable segment polarity.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 2,
    parameter int unsigned VALUE_WIDTH = 7,
    parameter int unsigned REFRESH_DIV = DEFAULT_REFRESH_DIV,
    parameter int unsigned GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    seg7_scan_driver_if.slave     host,
    input  logic                  lz_en,
    input  logic                  blank,
    input  logic                  seg_inv,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig
);

    localparam int unsigned PRESC_W   = cnt_width(REFRESH_DIV);
    localparam int unsigned IDX_W     = cnt_width(NUM_DIGITS);
    localparam int unsigned OVF_LIMIT = pow10(NUM_DIGITS);

    logic                    capture;
    logic                    conv_busy;
    logic                    conv_done;
    logic [4*NUM_DIGITS-1:0] conv_bcd;
    logic                    ovf_pending;
    logic [4*NUM_DIGITS-1:0] disp_bcd;
    logic                    disp_ovf;
    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        idx;
    logic [3:0]              cur_nib;
    logic                    cur_lz;
    logic                    hz;
    logic [6:0]              pattern;
    logic [NUM_DIGITS-1:0]   dig_next;

    assign capture   = host.load && !conv_busy;
    assign host.busy = conv_busy;

    bin2bcd_seq #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (capture),
        .value (host.value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_pending <= 1'b0;
            disp_bcd    <= '0;
            disp_ovf    <= 1'b0;
        end else begin
            if (capture) ovf_pending <= (32'(host.value) >= OVF_LIMIT);
            if (conv_done) begin
                disp_bcd <= conv_bcd;
                disp_ovf <= ovf_pending;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_W'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Walk from the most significant digit down so hz means "this digit and all above are zero".
    always_comb begin
        cur_nib = '0;
        cur_lz  = 1'b0;
        hz      = 1'b1;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            hz = hz && (disp_bcd[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
            if (32'(idx) == NUM_DIGITS - 1 - j) begin
                cur_nib = disp_bcd[4*(NUM_DIGITS-1-j) +: 4];
                cur_lz  = hz && (j != NUM_DIGITS - 1);
            end
        end
    end

    always_comb begin
        pattern = bcd_to_seg(cur_nib);
        if (disp_ovf)
            pattern = SEG_DASH;
        else if (lz_en && cur_lz)
            pattern = SEG_OFF;
    end

    always_comb begin
        dig_next = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++)
            dig_next[j] = (32'(idx) == j);
        if (presc < PRESC_W'(GUARD) || blank)
            dig_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= '0;
            dig <= '0;
        end else begin
            seg <= pattern ^ {7{seg_inv}};
            dig <= dig_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: DUT A (2 digits, 7-bit value), DUT B (3 digits, 10-bit value, 8-cycle slots).
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst;
    logic lz_en, blank, seg_inv;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dig_a;
    logic [2:0] dig_b;

    int checks   = 0;
    int failures = 0;

    seg7_scan_driver_if #(.VALUE_WIDTH(7))  if_a ();
    seg7_scan_driver_if #(.VALUE_WIDTH(10)) if_b ();

    seg7_scan_driver #(
        .NUM_DIGITS(2), .VALUE_WIDTH(7), .REFRESH_DIV(16), .GUARD(2)
    ) dut_a (
        .clk(clk), .rst(rst), .host(if_a), .lz_en(lz_en), .blank(blank),
        .seg_inv(seg_inv), .seg(seg_a), .dig(dig_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(3), .VALUE_WIDTH(10), .REFRESH_DIV(8), .GUARD(2)
    ) dut_b (
        .clk(clk), .rst(rst), .host(if_b), .lz_en(lz_en), .blank(blank),
        .seg_inv(seg_inv), .seg(seg_b), .dig(dig_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cur_dig(input int which);
        return (which == 0) ? 8'(dig_a) : 8'(dig_b);
    endfunction

    function automatic logic [6:0] cur_seg(input int which);
        return (which == 0) ? seg_a : seg_b;
    endfunction

    function automatic logic cur_busy(input int which);
        return (which == 0) ? if_a.busy : if_b.busy;
    endfunction

    task automatic set_value(input int which, input int unsigned val);
        if (which == 0) if_a.value = 7'(val);
        else            if_b.value = 10'(val);
    endtask

    task automatic set_load(input int which, input logic l);
        if (which == 0) if_a.load = l;
        else            if_b.load = l;
    endtask

    task automatic expect_slot(input int which, input int slot, input logic [6:0] exp, input string tag);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 64 && !found; c++) begin
            @(negedge clk);
            if (cur_dig(which) == 8'(1 << slot)) begin
                found = 1'b1;
                check(tag, 32'(cur_seg(which)), 32'(exp));
            end
        end
        if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Loads val; optionally pulses a second load (17) on the 3rd busy cycle.
    task automatic do_load(input int which, input int unsigned val, input bit inject, output int bcount);
        for (int c = 0; c < 100 && cur_busy(which); c++) @(negedge clk);
        set_value(which, val);
        set_load(which, 1'b1);
        @(negedge clk);
        set_load(which, 1'b0);
        bcount = 0;
        while (cur_busy(which) && bcount < 200) begin
            bcount++;
            if (inject && bcount == 3) begin
                set_value(which, 17);
                set_load(which, 1'b1);
            end else begin
                set_load(which, 1'b0);
            end
            @(negedge clk);
        end
        set_load(which, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        logic [7:0] exp_d;

        rst = 1'b1; lz_en = 1'b0; blank = 1'b0; seg_inv = 1'b0;
        if_a.value = '0; if_a.load = 1'b0;
        if_b.value = '0; if_b.load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg_a", 32'(seg_a), 32'h0);
        check("rst_dig_a", 32'(dig_a), 32'h0);
        check("rst_busy_a", 32'(if_a.busy), 32'h0);
        check("rst_seg_b", 32'(seg_b), 32'h0);
        check("rst_dig_b", 32'(dig_b), 32'h0);

        // Scan sequence after release: sample k reflects prescaler k mod slot length.
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            exp_d = ((k % 16) < 2) ? 8'h0 : 8'(1 << ((k / 16) % 2));
            check($sformatf("scan_a_dig_%0d", k), 32'(dig_a), 32'(exp_d));
            if (exp_d != 8'h0) check($sformatf("scan_a_seg_%0d", k), 32'(seg_a), 32'h3F);
            exp_d = ((k % 8) < 2) ? 8'h0 : 8'(1 << ((k / 8) % 3));
            check($sformatf("scan_b_dig_%0d", k), 32'(dig_b), 32'(exp_d));
        end

        do_load(0, 42, 1'b1, bc);
        check("busy_len_42", 32'(bc), 32'd7);
        @(negedge clk);
        check("no_queue", 32'(if_a.busy), 32'd0);
        expect_slot(0, 0, 7'h5B, "v42_d0");
        expect_slot(0, 1, 7'h66, "v42_d1");

        lz_en = 1'b1;
        do_load(0, 5, 1'b0, bc);
        expect_slot(0, 0, 7'h6D, "lz_d0");
        expect_slot(0, 1, 7'h00, "lz_d1");
        lz_en = 1'b0;
        @(negedge clk);
        expect_slot(0, 1, 7'h3F, "nolz_d1");

        do_load(0, 120, 1'b0, bc);
        expect_slot(0, 0, 7'h40, "ovf_d0");
        expect_slot(0, 1, 7'h40, "ovf_d1");
        seg_inv = 1'b1;
        @(negedge clk);
        expect_slot(0, 0, 7'h3F, "inv_ovf_d0");
        expect_slot(0, 1, 7'h3F, "inv_ovf_d1");
        do_load(0, 99, 1'b0, bc);
        expect_slot(0, 0, 7'h10, "inv_99_d0");
        seg_inv = 1'b0;
        @(negedge clk);

        expect_slot(0, 0, 7'h6F, "pre_blank");
        blank = 1'b1;
        check("blank_same_cycle", 32'(dig_a), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("blank_dig_%0d", k), 32'(dig_a), 32'h0);
            check($sformatf("blank_seg_%0d", k), 32'(seg_a), 32'h6F);
        end
        blank = 1'b0;
        expect_slot(0, 1, 7'h6F, "unblank_d1");

        // Reset lands on the 3rd busy cycle of a conversion.
        set_value(0, 88);
        set_load(0, 1'b1);
        @(negedge clk);
        set_load(0, 1'b0);
        check("mid_busy_c1", 32'(if_a.busy), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(if_a.busy), 32'd0);
        rst = 1'b0;
        expect_slot(0, 0, 7'h3F, "mid_rst_d0");
        expect_slot(0, 1, 7'h3F, "mid_rst_d1");
        do_load(0, 99, 1'b0, bc);
        check("busy_len_99", 32'(bc), 32'd7);
        expect_slot(0, 0, 7'h6F, "v99_d0");
        expect_slot(0, 1, 7'h6F, "v99_d1");

        do_load(1, 999, 1'b0, bc);
        check("busy_len_b", 32'(bc), 32'd10);
        expect_slot(1, 0, 7'h6F, "b999_d0");
        expect_slot(1, 1, 7'h6F, "b999_d1");
        expect_slot(1, 2, 7'h6F, "b999_d2");
        lz_en = 1'b1;
        do_load(1, 305, 1'b0, bc);
        expect_slot(1, 0, 7'h6D, "b305_d0");
        expect_slot(1, 1, 7'h3F, "b305_d1");
        expect_slot(1, 2, 7'h4F, "b305_d2");
        do_load(1, 7, 1'b0, bc);
        expect_slot(1, 0, 7'h07, "b7_d0");
        expect_slot(1, 1, 7'h00, "b7_d1");
        expect_slot(1, 2, 7'h00, "b7_d2");
        do_load(1, 1000, 1'b0, bc);
        expect_slot(1, 0, 7'h40, "b1000_d0");
        expect_slot(1, 2, 7'h40, "b1000_d2");
        lz_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
